// File: rtl/psum_drain_accumulator.sv
// Column drain: sums partial-sum vectors across K-tile passes, requantizes, queues results.
// Optional fused ReLU on requantized output: define PSUM_RELU_EN.
module psum_drain_accumulator #(
    parameter int P_BITWIDTH   = 40,
    parameter int ACC_BITWIDTH = 48,
    parameter int OUT_BITWIDTH = 16,
    parameter int VEC_LEN      = 16,
    parameter int FIFO_DEPTH   = 8,
    parameter int PASS_CNT_W   = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_start,
    input  logic [PASS_CNT_W-1:0]   cfg_pass_num,
    input  logic [5:0]              cfg_shift,
    input  logic [P_BITWIDTH-1:0]   p_data_in,
    input  logic                    p_valid_in,
    output logic [OUT_BITWIDTH-1:0] o_data,
    output logic                    o_valid,
    input  logic                    o_ready,
    output logic                    busy,
    output logic                    overflow_err
);

    localparam int EW = $clog2(VEC_LEN);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic signed [ACC_BITWIDTH:0] ONE = (ACC_BITWIDTH+1)'(1);
    localparam logic signed [ACC_BITWIDTH:0] SAT_MAX =
        {{(ACC_BITWIDTH-OUT_BITWIDTH+2){1'b0}}, {(OUT_BITWIDTH-1){1'b1}}};
    localparam logic signed [ACC_BITWIDTH:0] SAT_MIN =
        {{(ACC_BITWIDTH-OUT_BITWIDTH+2){1'b1}}, {(OUT_BITWIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        FLUSH
    } state_t;

    state_t                    state;
    logic [EW-1:0]             elem_cnt;
    logic [PASS_CNT_W-1:0]     pass_cnt;
    logic [PASS_CNT_W-1:0]     last_pass;
    logic [5:0]                shift_q;

    logic signed [ACC_BITWIDTH-1:0] acc_mem [VEC_LEN];
    logic signed [ACC_BITWIDTH-1:0] p_ext;
    logic signed [ACC_BITWIDTH-1:0] sum_now;
    logic                           take;
    logic                           is_first;
    logic                           is_last;
    logic                           elem_last;

    logic                           s_valid;
    logic signed [ACC_BITWIDTH-1:0] s_sum;
    logic                           rq_valid;
    logic [OUT_BITWIDTH-1:0]        rq_data;
    logic [OUT_BITWIDTH-1:0]        rq_next;

    logic signed [ACC_BITWIDTH:0]   sum_w;
    logic signed [ACC_BITWIDTH:0]   rnd;
    logic signed [ACC_BITWIDTH:0]   shifted;

    logic [OUT_BITWIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [AW:0]             count;
    logic                    full;
    logic                    pop;
    logic                    wr_en;

    assign p_ext     = {{(ACC_BITWIDTH-P_BITWIDTH){p_data_in[P_BITWIDTH-1]}}, p_data_in};
    assign take      = (state == ACCUM) && p_valid_in && !cfg_start;
    assign is_first  = (pass_cnt == '0);
    assign is_last   = (pass_cnt == last_pass);
    assign elem_last = (elem_cnt == EW'(VEC_LEN-1));
    assign sum_now   = is_first ? p_ext : acc_mem[elem_cnt] + p_ext;

    assign busy = (state != IDLE);

    // Element slots are revisited VEC_LEN cycles apart, so no forwarding is needed.
    always_ff @(posedge clk) begin
        if (take && !is_last)
            acc_mem[elem_cnt] <= sum_now;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            elem_cnt  <= '0;
            pass_cnt  <= '0;
            last_pass <= '0;
            shift_q   <= '0;
            s_valid   <= 1'b0;
            s_sum     <= '0;
        end else if (cfg_start) begin
            state     <= ACCUM;
            elem_cnt  <= '0;
            pass_cnt  <= '0;
            last_pass <= (cfg_pass_num == '0) ? '0 : cfg_pass_num - PASS_CNT_W'(1);
            shift_q   <= cfg_shift;
            s_valid   <= 1'b0;
        end else begin
            s_valid <= take && is_last;
            if (take && is_last)
                s_sum <= sum_now;
            if (take) begin
                if (elem_last) begin
                    elem_cnt <= '0;
                    if (is_last)
                        state <= FLUSH;
                    else
                        pass_cnt <= pass_cnt + PASS_CNT_W'(1);
                end else begin
                    elem_cnt <= elem_cnt + EW'(1);
                end
            end
            if (state == FLUSH && !s_valid && !rq_valid && count == '0)
                state <= IDLE;
        end
    end

    always_comb begin
        sum_w   = {s_sum[ACC_BITWIDTH-1], s_sum};
        rnd     = (shift_q == '0) ? '0 : (ONE << (shift_q - 6'd1));
        shifted = (sum_w + rnd) >>> shift_q;
        if (shifted > SAT_MAX)
            rq_next = {1'b0, {(OUT_BITWIDTH-1){1'b1}}};
        else if (shifted < SAT_MIN)
            rq_next = {1'b1, {(OUT_BITWIDTH-1){1'b0}}};
        else
            rq_next = shifted[OUT_BITWIDTH-1:0];
`ifdef PSUM_RELU_EN
        if (rq_next[OUT_BITWIDTH-1])
            rq_next = '0;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rq_valid <= 1'b0;
            rq_data  <= '0;
        end else if (cfg_start) begin
            rq_valid <= 1'b0;
        end else begin
            rq_valid <= s_valid;
            rq_data  <= rq_next;
        end
    end

    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign o_valid = (count != '0);
    assign o_data  = o_valid ? fifo_mem[rd_ptr] : '0;
    assign pop     = o_valid && o_ready;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign wr_en   = rq_valid && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr_en)
            fifo_mem[wr_ptr] <= rq_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_err <= 1'b0;
        end else if (cfg_start) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (rq_valid && full && !pop)
                overflow_err <= 1'b1;
            if (wr_en)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
